// File: rtl/mac_tree_pipe.sv
// Scalar-by-vector multiply, registered balanced adder tree and per-packet accumulation.
// Three register stages: products, tree sum, accumulator/result with a one-cycle write strobe.
module mac_tree_pipe #(
  parameter int DW        = 8,
  parameter int TAPS      = 9,
  parameter int MAX_BEATS = 4,
  parameter int SIGNED    = 0,
  localparam int SW       = 2*DW + $clog2(TAPS) + $clog2(MAX_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ALU_en,
  input  logic                 first,
  input  logic                 last,
  input  logic [DW-1:0]        A_input,
  input  logic [TAPS*DW-1:0]   X_vec,
  output logic [SW-1:0]        sum,
  output logic                 web,
  output logic                 ovf
);

  localparam int PW = 2*DW;
  localparam int LV = $clog2(TAPS);
  localparam int TW = PW + LV;
  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

  function automatic logic [PW-1:0] mul_f(input logic [DW-1:0] av, input logic [DW-1:0] xv);
    logic signed [PW-1:0] sp;
    logic        [PW-1:0] up;
    sp = $signed({{DW{av[DW-1]}}, av}) * $signed({{DW{xv[DW-1]}}, xv});
    up = {{DW{1'b0}}, av} * {{DW{1'b0}}, xv};
    return (SIGNED != 0) ? sp : up;
  endfunction

  function automatic logic [TW-1:0] ext_tw(input logic [PW-1:0] p);
    return (SIGNED != 0) ? TW'($signed(p)) : TW'(p);
  endfunction

  function automatic logic [SW-1:0] ext_sw(input logic [TW-1:0] t);
    return (SIGNED != 0) ? SW'($signed(t)) : SW'(t);
  endfunction

  logic [PW-1:0]  prod_p1_d [TAPS];
  logic [PW-1:0]  prod_p1_q [TAPS];
  logic           vld_p1_q, first_p1_q, last_p1_q;
  logic [TW-1:0]  tree_p2_d, tree_p2_q;
  logic           vld_p2_q, first_p2_q, last_p2_q;
  logic [SW-1:0]  acc_d, acc_q, acc_nx;
  logic [CW-1:0]  cnt_d, cnt_q, cnt_nx;
  logic [SW-1:0]  sum_d, sum_q;
  logic           web_d, web_q, ovf_d, ovf_q;

  // Stage 1: per-tap products; an idle beat loads zeros so the tree sees a clean bubble
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      prod_p1_d[i] = ALU_en ? mul_f(A_input, X_vec[(TAPS-1-i)*DW +: DW]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) prod_p1_q[i] <= '0;
      vld_p1_q   <= 1'b0;
      first_p1_q <= 1'b0;
      last_p1_q  <= 1'b0;
    end else begin
      for (int i = 0; i < TAPS; i++) prod_p1_q[i] <= prod_p1_d[i];
      vld_p1_q   <= ALU_en;
      first_p1_q <= ALU_en & first;
      last_p1_q  <= ALU_en & last;
    end
  end

  // Stage 2: pairwise tree; nodes are carried at full tree width, which is exact for every level
  always_comb begin : tree_c
    logic [TW-1:0] node [0:LV][0:TAPS];
    int n;
    for (int l = 0; l <= LV; l++) begin
      for (int j = 0; j <= TAPS; j++) node[l][j] = '0;
    end
    for (int j = 0; j < TAPS; j++) node[0][j] = ext_tw(prod_p1_q[j]);
    n = TAPS;
    for (int l = 1; l <= LV; l++) begin
      for (int j = 0; j < (TAPS + 1) / 2; j++) begin
        if (2*j + 1 < n)  node[l][j] = node[l-1][2*j] + node[l-1][2*j+1];
        else if (2*j < n) node[l][j] = node[l-1][2*j];
      end
      n = (n + 1) / 2;
    end
    tree_p2_d = node[LV][0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tree_p2_q  <= '0;
      vld_p2_q   <= 1'b0;
      first_p2_q <= 1'b0;
      last_p2_q  <= 1'b0;
    end else begin
      tree_p2_q  <= tree_p2_d;
      vld_p2_q   <= vld_p1_q;
      first_p2_q <= first_p1_q;
      last_p2_q  <= last_p1_q;
    end
  end

  // Stage 3: packet accumulation; a first beat restarts, a last beat publishes and clears
  always_comb begin
    acc_nx = first_p2_q ? ext_sw(tree_p2_q) : acc_q + ext_sw(tree_p2_q);
    cnt_nx = first_p2_q ? CW'(1) : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1);
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    sum_d  = sum_q;
    web_d  = 1'b0;
    ovf_d  = 1'b0;
    if (vld_p2_q) begin
      if (last_p2_q) begin
        sum_d = acc_nx;
        web_d = 1'b1;
        ovf_d = (cnt_nx > CNT_MAX);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = acc_nx;
        cnt_d = cnt_nx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      web_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      web_q <= web_d;
      ovf_q <= ovf_d;
    end
  end

  assign sum = sum_q;
  assign web = web_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mac_tree_pipe.sv
// Bench for mac_tree_pipe: directed packet scenarios on unsigned and signed instances,
// then random beats checked against a packet-level integer model.
module tb_mac_tree_pipe;

  localparam int SW = 22;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst, en, fi, la;
  logic [7:0]  a;
  logic [71:0] x;
  logic [21:0] sum_u, sum_s;
  logic        web_u, web_s, ovf_u, ovf_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_tree_pipe #(.DW(8), .TAPS(9), .MAX_BEATS(MB), .SIGNED(0)) u_dut_u (
    .clk(clk), .rst(rst), .ALU_en(en), .first(fi), .last(la),
    .A_input(a), .X_vec(x), .sum(sum_u), .web(web_u), .ovf(ovf_u));

  mac_tree_pipe #(.DW(8), .TAPS(9), .MAX_BEATS(MB), .SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .ALU_en(en), .first(fi), .last(la),
    .A_input(a), .X_vec(x), .sum(sum_s), .web(web_s), .ovf(ovf_s));

  typedef struct {
    bit          web;
    bit          ovf;
    logic [21:0] su;
    logic [21:0] ss;
  } exp_t;

  exp_t        pipe_q[$];
  exp_t        cur;
  longint      acc_u, acc_s;
  int          cnt;
  logic [21:0] held_u, held_s;

  function automatic longint dot(input logic [7:0] av, input logic [71:0] xv, input bit sgn);
    longint      s;
    logic [7:0]  xi;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      xi = xv[(8-i)*8 +: 8];
      if (sgn) s += longint'($signed(av)) * longint'($signed(xi));
      else     s += longint'(av) * longint'(xi);
    end
    return s;
  endfunction

  function automatic logic [71:0] xfill(input logic [7:0] v);
    return {9{v}};
  endfunction

  function automatic logic [71:0] xramp();
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[(8-i)*8 +: 8] = 8'(i + 1);
    return r;
  endfunction

  // Drive one cycle, then update the packet model; cur holds what the outputs must show now
  task automatic step(input bit r, input bit e, input bit f, input bit l,
                      input logic [7:0] av, input logic [71:0] xv);
    exp_t it;
    rst = r; en = e; fi = f; la = l; a = av; x = xv;
    @(posedge clk);
    #1;
    it = '{default: 0};
    if (!r) begin
      pipe_q.delete();
      acc_u = 0; acc_s = 0; cnt = 0; held_u = '0; held_s = '0;
      pipe_q.push_back(it);
      pipe_q.push_back(it);
      cur = it;
    end else begin
      if (e) begin
        if (f) begin
          acc_u = dot(av, xv, 1'b0);
          acc_s = dot(av, xv, 1'b1);
          cnt   = 1;
        end else begin
          acc_u += dot(av, xv, 1'b0);
          acc_s += dot(av, xv, 1'b1);
          cnt   = (cnt > MB) ? cnt : cnt + 1;
        end
        if (l) begin
          it.web = 1'b1;
          it.ovf = (cnt > MB);
          it.su  = SW'(acc_u);
          it.ss  = SW'(acc_s);
          acc_u = 0; acc_s = 0; cnt = 0;
        end
      end
      pipe_q.push_back(it);
      cur = pipe_q.pop_front();
      if (cur.web) begin
        held_u = cur.su;
        held_s = cur.ss;
      end else begin
        cur.su = held_u;
        cur.ss = held_s;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, xfill(8'hFF));
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, xfill(8'hFF));
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, '0);
    n_cmp++; if (sum_u !== 22'd0) begin n_bad++; $display("FAIL reset_sum_u: got %0d want 0", sum_u); end
    n_cmp++; if (web_u !== 1'b0)  begin n_bad++; $display("FAIL reset_web_u: got %b want 0", web_u); end
    n_cmp++; if (ovf_u !== 1'b0)  begin n_bad++; $display("FAIL reset_ovf_u: got %b want 0", ovf_u); end
    n_cmp++; if (sum_s !== 22'd0) begin n_bad++; $display("FAIL reset_sum_s: got %0d want 0", sum_s); end
    n_cmp++; if (web_s !== 1'b0)  begin n_bad++; $display("FAIL reset_web_s: got %b want 0", web_s); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      n_cmp++; if (web_u !== 1'b0) begin n_bad++; $display("FAIL post_reset_web: got %b want 0 at cycle %0d", web_u, i); end
    end
  endtask

  task automatic test_unsigned_single();
    int nweb = 0, widx = -1;
    logic [21:0] ws = '0;
    logic wo = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, xfill(8'hFF));
      else        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      if (web_u === 1'b1) begin nweb++; widx = i; ws = sum_u; wo = ovf_u; end
    end
    n_cmp++; if (nweb != 1)      begin n_bad++; $display("FAIL uns_web_count: got %0d want 1", nweb); end
    n_cmp++; if (widx != 2)      begin n_bad++; $display("FAIL uns_latency: web at %0d want 2", widx); end
    n_cmp++; if (ws !== 22'd585225) begin n_bad++; $display("FAIL uns_sum: got %0d want 585225", ws); end
    n_cmp++; if (wo !== 1'b0)    begin n_bad++; $display("FAIL uns_ovf: got %b want 0", wo); end
    n_cmp++; if (sum_s !== 22'd9) begin n_bad++; $display("FAIL uns_as_signed_sum: got %0d want 9", sum_s); end
  endtask

  task automatic test_signed_single();
    int nweb = 0;
    logic [21:0] ws = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, xfill(8'h03));
      else        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
      if (web_s === 1'b1) begin nweb++; ws = sum_s; end
    end
    n_cmp++; if (nweb != 1)          begin n_bad++; $display("FAIL sgn_web_count: got %0d want 1", nweb); end
    n_cmp++; if (ws !== 22'h3FFFCA)  begin n_bad++; $display("FAIL sgn_sum: got %h want 3fffca", ws); end
    n_cmp++; if (sum_u !== 22'd6858) begin n_bad++; $display("FAIL sgn_as_unsigned_sum: got %0d want 6858", sum_u); end
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h80, xfill(8'h80));
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, '0);
    n_cmp++; if (sum_s !== 22'd147456) begin n_bad++; $display("FAIL sgn_min_sq: got %0d want 147456", sum_s); end
    n_cmp++; if (web_s !== 1'b1)       begin n_bad++; $display("FAIL sgn_min_sq_web: got %b want 1", web_s); end
  endtask

  task automatic test_multibeat_gap();
    int nweb = 0, widx = -1;
    logic [21:0] ws = '0;
    logic wo = 1'b1;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, xramp());
        1, 3:    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, xramp());
        4:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, xramp());
        default: step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      endcase
      if (web_u === 1'b1) begin nweb++; widx = i; ws = sum_u; wo = ovf_u; end
    end
    n_cmp++; if (nweb != 1)       begin n_bad++; $display("FAIL gap_web_count: got %0d want 1", nweb); end
    n_cmp++; if (widx != 6)       begin n_bad++; $display("FAIL gap_latency: web at %0d want 6", widx); end
    n_cmp++; if (ws !== 22'd180)  begin n_bad++; $display("FAIL gap_sum: got %0d want 180", ws); end
    n_cmp++; if (wo !== 1'b0)     begin n_bad++; $display("FAIL gap_ovf: got %b want 0", wo); end
  endtask

  task automatic test_overflow_back_to_back();
    int nweb = 0;
    int widx [2] = '{-1, -1};
    logic [21:0] ws [2] = '{22'd0, 22'd0};
    logic wo [2] = '{1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, xfill(8'd1));
        1, 2, 3: step(1'b1, 1'b1, 1'b0, 1'b0, 8'd1, xfill(8'd1));
        4:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, xfill(8'd1));
        5:       step(1'b1, 1'b1, 1'b1, 1'b1, 8'd2, xfill(8'd1));
        default: step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      endcase
      if (web_u === 1'b1) begin
        if (nweb < 2) begin widx[nweb] = i; ws[nweb] = sum_u; wo[nweb] = ovf_u; end
        nweb++;
      end
    end
    n_cmp++; if (nweb != 2)          begin n_bad++; $display("FAIL ovf_web_count: got %0d want 2", nweb); end
    n_cmp++; if (widx[0] != 6)       begin n_bad++; $display("FAIL ovf_latency: web at %0d want 6", widx[0]); end
    n_cmp++; if (ws[0] !== 22'd45)   begin n_bad++; $display("FAIL ovf_sum: got %0d want 45", ws[0]); end
    n_cmp++; if (wo[0] !== 1'b1)     begin n_bad++; $display("FAIL ovf_flag: got %b want 1", wo[0]); end
    n_cmp++; if (widx[1] != 7)       begin n_bad++; $display("FAIL b2b_latency: web at %0d want 7", widx[1]); end
    n_cmp++; if (ws[1] !== 22'd18)   begin n_bad++; $display("FAIL b2b_sum: got %0d want 18", ws[1]); end
    n_cmp++; if (wo[1] !== 1'b0)     begin n_bad++; $display("FAIL b2b_ovf: got %b want 0", wo[1]); end
  endtask

  task automatic test_reset_mid_packet();
    int nweb = 0, widx = -1;
    logic [21:0] ws = '0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 1'b1, 1'b0, 8'd5, xfill(8'd7));
        1:       step(1'b1, 1'b1, 1'b0, 1'b0, 8'd5, xfill(8'd7));
        2:       step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        3:       step(1'b1, 1'b1, 1'b1, 1'b1, 8'd1, xfill(8'd1));
        default: step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      endcase
      if (i == 2) begin
        n_cmp++; if (sum_u !== 22'd0) begin n_bad++; $display("FAIL rstmid_sum: got %0d want 0", sum_u); end
        n_cmp++; if (web_u !== 1'b0)  begin n_bad++; $display("FAIL rstmid_web: got %b want 0", web_u); end
      end
      if (web_u === 1'b1) begin nweb++; widx = i; ws = sum_u; end
    end
    n_cmp++; if (nweb != 1)     begin n_bad++; $display("FAIL rstmid_web_count: got %0d want 1", nweb); end
    n_cmp++; if (widx != 5)     begin n_bad++; $display("FAIL rstmid_latency: web at %0d want 5", widx); end
    n_cmp++; if (ws !== 22'd9)  begin n_bad++; $display("FAIL rstmid_sum_after: got %0d want 9", ws); end
  endtask

  task automatic test_restart();
    int nweb = 0;
    logic [21:0] ws = '0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 1'b1, 1'b0, 8'd3, xfill(8'd1));
        1:       step(1'b1, 1'b1, 1'b0, 1'b0, 8'd3, xfill(8'd1));
        2:       step(1'b1, 1'b1, 1'b1, 1'b0, 8'd1, xfill(8'd1));
        3:       step(1'b1, 1'b1, 1'b0, 1'b1, 8'd1, xfill(8'd1));
        default: step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      endcase
      if (web_u === 1'b1) begin nweb++; ws = sum_u; end
    end
    n_cmp++; if (nweb != 1)      begin n_bad++; $display("FAIL restart_web_count: got %0d want 1", nweb); end
    n_cmp++; if (ws !== 22'd18)  begin n_bad++; $display("FAIL restart_sum: got %0d want 18", ws); end
    n_cmp++; if (sum_s !== 22'd18) begin n_bad++; $display("FAIL restart_sum_s: got %0d want 18", sum_s); end
  endtask

  task automatic test_random();
    bit r, e, f, l;
    logic [7:0]  av;
    logic [71:0] xv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) >= 2);
      e  = ($urandom_range(0, 99) < 75);
      f  = ($urandom_range(0, 99) < 25);
      l  = ($urandom_range(0, 99) < 30);
      av = 8'($urandom);
      xv = {8'($urandom), 32'($urandom), 32'($urandom)};
      step(r, e, f, l, av, xv);
      n_cmp++; if (web_u !== cur.web) begin n_bad++; $display("FAIL rnd_web_u: got %b want %b at %0d", web_u, cur.web, i); end
      n_cmp++; if (web_s !== cur.web) begin n_bad++; $display("FAIL rnd_web_s: got %b want %b at %0d", web_s, cur.web, i); end
      n_cmp++; if (sum_u !== cur.su)  begin n_bad++; $display("FAIL rnd_sum_u: got %h want %h at %0d", sum_u, cur.su, i); end
      n_cmp++; if (sum_s !== cur.ss)  begin n_bad++; $display("FAIL rnd_sum_s: got %h want %h at %0d", sum_s, cur.ss, i); end
      if (cur.web) begin
        n_cmp++; if (ovf_u !== cur.ovf) begin n_bad++; $display("FAIL rnd_ovf_u: got %b want %b at %0d", ovf_u, cur.ovf, i); end
        n_cmp++; if (ovf_s !== cur.ovf) begin n_bad++; $display("FAIL rnd_ovf_s: got %b want %b at %0d", ovf_s, cur.ovf, i); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; fi = 1'b0; la = 1'b0; a = '0; x = '0;
    test_reset();
    test_unsigned_single();
    test_signed_single();
    test_multibeat_gap();
    test_overflow_back_to_back();
    test_reset_mid_packet();
    test_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_tree_pipe.md
Name: mac_tree_pipe

Overview:
- Parametrised successor of the 9-product multiply-sum ALU in the matrix datapath.
- Multiplies one scalar A element by a packed vector of TAPS X elements, then reduces the products through a registered adder tree.
- Accumulates the tree result across a multi-beat packet marked by first/last flags.
- Emits one result word plus a one-cycle write strobe to the result memory per packet.

Parameters:
- DW, 8: element width of A_input and of each X element.
- TAPS, 9: number of X elements (products) per beat; range 2..16.
- MAX_BEATS, 4: maximum beats per packet that the sum width is sized for; power of two, at least 1.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands, with products and sums sign-extended.
- SW, 2*DW+$clog2(TAPS)+$clog2(MAX_BEATS): sum width (22 at defaults). Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- ALU_en  in  1  input beat valid.
- first  in  1  beat starts a packet; qualified by ALU_en.
- last  in  1  beat ends a packet; qualified by ALU_en.
- A_input  in  DW  scalar operand.
- X_vec  in  TAPS*DW  element i is X_vec[(TAPS-1-i)*DW +: DW]; element 0 is the MSB slice.
- sum  out  SW  packet result; held until the next result.
- web  out  1  write strobe, high for exactly one cycle when sum updates.
- ovf  out  1  high with web when the packet contained more than MAX_BEATS beats.

Behaviour:
- Reset:
  - While rst=0 at a clock edge, every pipeline register, valid bit, the accumulator and the beat counter clear to 0.
  - sum=0, web=0, ovf=0.
  - Reset mid-packet discards the in-flight packet; no web is produced for it.
- Stage 1 (edge E):
  - If ALU_en=1, register the TAPS products A_input*X[i], each 2*DW bits (signed or unsigned per SIGNED).
  - Also register v1=1, first and last.
  - If ALU_en=0, v1=0 and the product registers load 0. This bubble does not disturb the accumulator.
- Stage 2 (edge E+1):
  - Balanced binary adder tree over the TAPS products, fully combinational between stage 1 and stage 2.
  - Each tree level widens by 1 bit; an odd leftover operand passes to the next level unchanged, zero- or sign-extended.
  - Register the tree result at $clog2(TAPS) bits above 2*DW, together with v2, first and last.
- Stage 3 (edge E+2), when v2=1:
  - If first=1: acc = tree, extended to SW; cnt = 1.
  - Else: acc = acc + tree, modulo 2^SW (wrap, no saturation); cnt = cnt + 1, saturating at MAX_BEATS+1.
  - If last=1: sum = new acc value; web=1; ovf = (new cnt > MAX_BEATS). Then acc and cnt clear to 0 on the same edge.
  - If last=0: web=0; sum holds.
  - When v2=0, acc, cnt and sum hold and web=0.
- Latency and throughput:
  - Latency: a last beat sampled on edge E gives web=1 and a valid sum in the cycle after edge E+2, i.e. 3 cycles.
  - Throughput: one beat per cycle with no backpressure. Back-to-back packets, including consecutive single-beat packets, produce web on consecutive cycles.
- Boundary cases:
  - first=1 and last=1 in the same beat: single-beat packet; sum = tree result.
  - A beat without first following a completed packet accumulates onto the cleared acc (0). It is still counted, and the packet is well formed only if it later sees last.
  - first=1 while a packet is open: the open packet is abandoned without web; accumulation restarts.
  - first/last with ALU_en=0: ignored.
  - Idle gaps (ALU_en=0) inside a packet are allowed; the accumulator holds across them.
- Widths and signedness:
  - With SIGNED=1, A=-128 and X=-128 gives a product of +16384, representable in 2*DW.
  - All extensions follow SIGNED.
  - No internal truncation occurs below SW.

Test Plan:
- Unsigned single beat: SIGNED=0, A=255, all nine X=255, first=last=1 -> 3 cycles later web=1 for one cycle, sum=585225, ovf=0.
- Signed single beat: SIGNED=1, A=0xFE (-2), all X=3 -> sum=-54 (0x3FFFCA in 22 bits), web=1.
- Multi-beat with gap: 4 beats (first on beat 1, last on beat 4, one ALU_en=0 cycle between beats 2 and 3), A=1, X=1..9 -> single web, sum=180, ovf=0, no web on intermediate beats.
- Overflow: 5-beat packet, A=1, X all 1 -> sum=45, ovf=1; back-to-back single-beat packet A=2, X all 1 -> web on the next cycle, sum=18, ovf=0.
- Reset mid-packet: drive 2 beats (first, no last), assert rst=0 for one cycle, then a single-beat packet A=1, X all 1 -> only one web, sum=9; sum=0, web=0 while in reset.
- Restart: first without a preceding last on an open packet -> no web for the abandoned packet; result equals the new packet only.
